// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter.
//   - Owner-state encoding (IDLE / OWN0 / OWN1)
//   - Port identifiers (PORT_CPU = 0, PORT_DMA = 1)
//   - Saturating 4-bit increment used by the burst counter
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Increment that sticks at 15 so a long uncontended burst never wraps
  // back below MAX_BURST and starves the other port.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    logic [3:0] res;
    if (val == 4'd15) begin
      res = 4'd15;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates one single-ported data memory between a processor load/store
// port (port 0) and a loader/DMA port (port 1). The grant is combinational
// in the request cycle; the owner may take up to MAX_BURST consecutive
// accepts while the other port waits. The response for an accepted access
// is registered and appears exactly one cycle later.
//
// Parameters
//   AW         address width
//   DW         data width
//   MAX_BURST  consecutive accepts allowed while the other port waits (1..15)
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   req*/we*/addr*/wdata*         requester inputs, port 0 and port 1
//   gnt0/gnt1                     accept strobes (at most one high)
//   rsp_valid/port/we/rdata       registered response, one cycle after accept
//   mem_address/write_data        memory request from the granted port
//   mem_read/mem_write            memory strobes, both 0 when nothing granted
//   mem_read_data                 combinational read data from the memory
//   stat_gnt0/stat_gnt1/stat_wait statistics counters
//
// Build option
//   DMEM_ARB_STATS_EN  when defined, the statistics counters are built;
//                      otherwise the statistics outputs are tied to 0.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rsp_valid,
  output logic          rsp_port,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data,
  output logic [31:0]   stat_gnt0,
  output logic [31:0]   stat_gnt1,
  output logic [31:0]   stat_wait
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic [1:0] state_r;
  logic       last_r;
  logic [3:0] burst_cnt_r;

  logic       gnt0_s;
  logic       gnt1_s;
  logic       accept_s;
  logic       sel_we_s;
  logic [1:0] owner_nxt_s;
  logic       burst_ok_s;

  assign burst_ok_s = (burst_cnt_r < MAX_BURST_C);

  // Grant decision; reset forces both grants low in the same cycle.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        ST_OWN0: begin
          // Owner keeps the memory until its burst quota is used, then
          // yields if the other port is waiting.
          if (req0 && burst_ok_s) begin
            gnt0_s = 1'b1;
          end else if (req1) begin
            gnt1_s = 1'b1;
          end else if (req0) begin
            gnt0_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
          end
        end
        ST_OWN1: begin
          if (req1 && burst_ok_s) begin
            gnt1_s = 1'b1;
          end else if (req0) begin
            gnt0_s = 1'b1;
          end else if (req1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt1_s = 1'b0;
          end
        end
        default: begin
          // IDLE (and any illegal encoding): a tie goes to the port that
          // was not granted last.
          if (req0 && req1) begin
            if (last_r == PORT_DMA) begin
              gnt0_s = 1'b1;
            end else begin
              gnt1_s = 1'b1;
            end
          end else if (req0) begin
            gnt0_s = 1'b1;
          end else if (req1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt0        = gnt0_s;
  assign gnt1        = gnt1_s;
  assign accept_s    = gnt0_s | gnt1_s;
  assign sel_we_s    = gnt1_s ? we1 : we0;
  assign owner_nxt_s = gnt1_s ? ST_OWN1 : ST_OWN0;

  // Memory request mux from the granted port; quiet when nothing is granted.
  always_comb begin
    mem_address    = {AW{1'b0}};
    mem_write_data = {DW{1'b0}};
    if (gnt1_s) begin
      mem_address    = addr1;
      mem_write_data = wdata1;
    end else if (gnt0_s) begin
      mem_address    = addr0;
      mem_write_data = wdata0;
    end else begin
      mem_address    = {AW{1'b0}};
      mem_write_data = {DW{1'b0}};
    end
  end

  assign mem_read  = accept_s & ~sel_we_s;
  assign mem_write = accept_s &  sel_we_s;

  // Ownership state, last-granted port and burst length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_r      <= PORT_DMA;
      burst_cnt_r <= 4'd0;
    end else if (accept_s) begin
      state_r <= owner_nxt_s;
      last_r  <= gnt1_s;
      // A change of owner (including leaving IDLE) starts a new burst.
      if (state_r != owner_nxt_s) begin
        burst_cnt_r <= 4'd1;
      end else begin
        burst_cnt_r <= sat_inc4(burst_cnt_r);
      end
    end else begin
      state_r     <= ST_IDLE;
      last_r      <= last_r;
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Single-stage response register; an accept always produces a response
  // on the following cycle, so no buffering is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_CPU;
      rsp_we    <= 1'b0;
      rsp_rdata <= {DW{1'b0}};
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_port  <= gnt1_s;
      rsp_we    <= sel_we_s;
      rsp_rdata <= sel_we_s ? {DW{1'b0}} : mem_read_data;
    end else begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_CPU;
      rsp_we    <= 1'b0;
      rsp_rdata <= {DW{1'b0}};
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_r;
  logic [31:0] stat_gnt1_r;
  logic [31:0] stat_wait_r;
  logic        wait_s;

  // One wait tick per cycle in which any request is left ungranted.
  assign wait_s = (req0 & ~gnt0_s) | (req1 & ~gnt1_s);

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_gnt0_r <= 32'd0;
      stat_gnt1_r <= 32'd0;
      stat_wait_r <= 32'd0;
    end else begin
      stat_gnt0_r <= stat_gnt0_r + {31'd0, gnt0_s};
      stat_gnt1_r <= stat_gnt1_r + {31'd0, gnt1_s};
      stat_wait_r <= stat_wait_r + {31'd0, wait_s};
    end
  end

  assign stat_gnt0 = stat_gnt0_r;
  assign stat_gnt1 = stat_gnt1_r;
  assign stat_wait = stat_wait_r;
`else
  assign stat_gnt0 = 32'd0;
  assign stat_gnt1 = 32'd0;
  assign stat_wait = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized request traffic, all compared against a behavioural model of the
// arbitration rules and a reference memory image kept in the bench.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = 32'd0, addr1 = 32'd0;
  logic [DW-1:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic          gnt0, gnt1, rsp_valid, rsp_port, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_read_data;
  logic [31:0]   stat_gnt0, stat_gnt1, stat_wait;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_wait(stat_wait)
  );

  // Environment memory: 64 words, indexed by word address bits [7:2].
  logic [DW-1:0] env_mem [0:63];
  bit            env_ready = 1'b0;

  always_comb mem_read_data = env_mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 32'h0101_0101 * 32'(i);
    end else if (mem_write) begin
      env_mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:63];
  int            m_owner;   // -1 = nobody, else owning port
  int            m_cnt;
  int            m_last;
  bit            e_valid, e_port, e_we;
  logic [DW-1:0] e_rdata;
  logic [31:0]   m_sg0, m_sg1, m_sw;
  bit            ready = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Which port the arbitration rules pick this cycle (-1 = none).
  function automatic int model_grant(input bit rst, input bit r0, input bit r1);
    bit rk, ro;
    if (!rst) return -1;
    if (m_owner < 0) begin
      if (r0 && r1) return 1 - m_last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    rk = (m_owner == 1) ? r1 : r0;
    ro = (m_owner == 1) ? r0 : r1;
    if (rk && m_cnt < MB) return m_owner;
    if (ro) return 1 - m_owner;
    if (rk) return m_owner;
    return -1;
  endfunction

  // One clock cycle: check registered outputs, apply inputs, check the
  // combinational outputs, then advance the model across the edge.
  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                      output int obs);
    int g;
    bit gw;
    logic [31:0] ga, gd;
    @(negedge clk);
    if (ready) begin
      check_eq("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
        check_eq("rsp_port", rsp_port, e_port);
        check_eq("rsp_we", rsp_we, e_we);
        check_eq("rsp_rdata", rsp_rdata, e_rdata);
      end
`ifdef DMEM_ARB_STATS_EN
      check_eq("stat_gnt0", stat_gnt0, m_sg0);
      check_eq("stat_gnt1", stat_gnt1, m_sg1);
      check_eq("stat_wait", stat_wait, m_sw);
`else
      check_eq("stat_gnt0", stat_gnt0, 32'd0);
      check_eq("stat_gnt1", stat_gnt1, 32'd0);
      check_eq("stat_wait", stat_wait, 32'd0);
`endif
    end
    rst_n = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    g   = model_grant(rst, r0, r1);
    obs = gnt1 ? 1 : (gnt0 ? 0 : -1);
    gw  = (g == 1) ? w1 : w0;
    ga  = (g == 1) ? a1 : a0;
    gd  = (g == 1) ? d1 : d0;
    check_eq("gnt0", gnt0, (g == 0));
    check_eq("gnt1", gnt1, (g == 1));
    check_eq("mem_read", mem_read, (g >= 0) && !gw);
    check_eq("mem_write", mem_write, (g >= 0) && gw);
    if (g >= 0) begin
      check_eq("mem_address", mem_address, ga);
      if (gw) check_eq("mem_write_data", mem_write_data, gd);
    end
    @(posedge clk);
    if (!rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0;
      e_valid = 1'b0; e_port = 1'b0; e_we = 1'b0; e_rdata = 32'd0;
      m_sg0 = 32'd0; m_sg1 = 32'd0; m_sw = 32'd0;
      ready = 1'b1;
    end else begin
      if (g == 0) m_sg0 = m_sg0 + 32'd1;
      if (g == 1) m_sg1 = m_sg1 + 32'd1;
      if ((r0 && g != 0) || (r1 && g != 1)) m_sw = m_sw + 32'd1;
      if (g >= 0) begin
        m_cnt   = (m_owner != g) ? 1 : ((m_cnt >= 15) ? 15 : m_cnt + 1);
        m_owner = g;
        m_last  = g;
        e_valid = 1'b1; e_port = (g == 1); e_we = gw;
        e_rdata = gw ? 32'd0 : ref_mem[ga[7:2]];
        if (gw) ref_mem[ga[7:2]] = gd;
      end else begin
        m_owner = -1;
        e_valid = 1'b0; e_port = 1'b0; e_we = 1'b0; e_rdata = 32'd0;
      end
    end
  endtask

  int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    int obs;
    bit p0, p1, w0r, w1r, rr;
    logic [31:0] a0r, a1r, d0r, d1r;
    int wt0, wt1;

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0101_0101 * 32'(i);
    m_owner = -1; m_last = 1; m_cnt = 0;
    e_valid = 1'b0; e_port = 1'b0; e_we = 1'b0; e_rdata = 32'd0;
    m_sg0 = 32'd0; m_sg1 = 32'd0; m_sw = 32'd0;

    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, obs);
    env_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, obs);
    #1;
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);

    // Both ports reading continuously from reset: 4/4 burst alternation.
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, obs);
    check_eq("first_grant_port", obs, 0);
    #1;
    check_eq("first_rsp_valid", rsp_valid, 1'b1);
    check_eq("first_rsp_port", rsp_port, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, obs);
      check_eq("burst_seq", obs, exp_seq[i]);
    end
    #1;
`ifdef DMEM_ARB_STATS_EN
    check_eq("stats_gnt_sum", stat_gnt0 + stat_gnt1, 32'd10);
    check_eq("stats_wait10", stat_wait, 32'd10);
`else
    check_eq("stats_gnt_sum", stat_gnt0 + stat_gnt1, 32'd0);
    check_eq("stats_wait10", stat_wait, 32'd0);
`endif

    // Port 1 writes, port 0 reads the same word back.
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, obs);
    #1;
    check_eq("wr_ack_we", rsp_we, 1'b1);
    check_eq("wr_ack_port", rsp_port, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, obs);
    #1;
    check_eq("rd_back_data", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_back_port", rsp_port, 1'b0);
    check_eq("rd_back_we", rsp_we, 1'b0);

    // Reset in the middle of a port-1 write burst.
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h44, 32'h1234_5678, obs);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h48, 32'h9ABC_DEF0, obs);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h4C, 32'h0BAD_F00D, obs);
    #1;
    check_eq("mid_reset_rsp_valid", rsp_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 1'b1, 1'b0, 32'h48, 32'd0, obs);
    check_eq("post_reset_grant", obs, 0);

    // Randomized traffic with occasional resets; requests held until granted.
    p0 = 1'b0; p1 = 1'b0; wt0 = 0; wt1 = 0;
    w0r = 1'b0; w1r = 1'b0; a0r = 32'd0; a1r = 32'd0; d0r = 32'd0; d1r = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; w0r = 1'($urandom_range(0, 1));
        a0r = {24'd0, 6'($urandom_range(0, 63)), 2'b00}; d0r = $urandom; wt0 = 0;
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; w1r = 1'($urandom_range(0, 1));
        a1r = {24'd0, 6'($urandom_range(0, 63)), 2'b00}; d1r = $urandom; wt1 = 0;
      end
      rr = ($urandom_range(0, 199) != 0);
      step(rr, p0, w0r, a0r, d0r, p1, w1r, a1r, d1r, obs);
      if (rr) begin
        if (p0) begin
          if (obs == 0) begin
            check_eq("wait_bound0", (wt0 <= MB), 1'b1);
            p0 = 1'b0;
          end else begin
            wt0++;
          end
        end
        if (p1) begin
          if (obs == 1) begin
            check_eq("wait_bound1", (wt1 <= MB), 1'b1);
            p1 = 1'b0;
          end else begin
            wt1++;
          end
        end
      end else begin
        wt0 = 0; wt1 = 0;
      end
    end
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, obs);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_BURST, default 4, range 1..15, maximum consecutive accepts by one owner while the other port waits.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req0/req1  input  1  request valid, port 0 (processor load/store), port 1 (loader/DMA).
REQ-007 we0/we1  input  1  1 = write, 0 = read.
REQ-008 addr0/addr1  input  AW  byte address.
REQ-009 wdata0/wdata1  input  DW  write data.
REQ-010 gnt0/gnt1  output  1  request accepted this cycle; at most one high.
REQ-011 rsp_valid  output  1  response for the access accepted in the previous cycle.
REQ-012 rsp_port  output  1  port owning the response.
REQ-013 rsp_we  output  1  response is a write acknowledge.
REQ-014 rsp_rdata  output  DW  read data; 0 for writes.
REQ-015 mem_address  output  AW  to data memory.
REQ-016 mem_write_data  output  DW  to data memory.
REQ-017 mem_read/mem_write  output  1  to data memory; both 0 when no grant.
REQ-018 mem_read_data  input  DW  combinational read data from data memory.
REQ-019 stat_gnt0/stat_gnt1/stat_wait  output  32  statistics counters (see Configuration).

Function
REQ-020 States IDLE, OWN0, OWN1; burst_cnt (4 bits); last (1 bit, last granted port).
REQ-021 Grant is combinational in the cycle of the request; req held until gnt, transfer occurs when reqK and gntK are both high.
REQ-022 In OWNk: if reqk and burst_cnt < MAX_BURST, grant k; else if the other port requests, grant the other port; else if reqk, grant k.
REQ-023 In IDLE: a single requester is granted; if both request, grant port !last.
REQ-024 Next state is OWNk when port k is granted, IDLE when no grant; last <= granted port.
REQ-025 burst_cnt <= 1 on grant to a new owner or from IDLE, else burst_cnt+1, saturating at 15; holds in IDLE.
REQ-026 A waiting requester is granted within MAX_BURST cycles of asserting req.
REQ-027 Memory outputs mux from the granted port; mem_read = grant & !we, mem_write = grant & we.
REQ-028 Latency 1: rsp_valid, rsp_port, rsp_we, rsp_rdata are registered from the accept cycle; rsp_rdata captures mem_read_data for reads.
REQ-029 Back-to-back accepts produce back-to-back responses; no response buffering, no backpressure on responses.

Reset
REQ-030 While rst_n is low, gnt0/gnt1, mem_read and mem_write are forced 0 combinationally.
REQ-031 On a clock edge with rst_n low: state IDLE, last=1, burst_cnt=0, rsp_valid=0, rsp_port=0, rsp_we=0, rsp_rdata=0, statistics counters 0.
REQ-032 Reset mid-burst discards any in-flight response; the first grant after reset follows the IDLE rules.

Configuration
REQ-033 Macro DMEM_ARB_STATS_EN defined: stat_gnt0/stat_gnt1 increment on each accept by that port; stat_wait increments each cycle a request is pending without grant; all wrap at 2^32.
REQ-034 Macro undefined: statistics outputs are constant 0 and no counter registers are synthesized.

Structure
REQ-035 Package dmem_arb_pkg holds the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and port-ID constants PORT_CPU=0, PORT_DMA=1.
REQ-036 No sub-modules; single flat module.

Verification
REQ-037 After reset, req0=req1=1 (reads) at the same cycle -> gnt0 first (last=1), rsp_port=0 one cycle later.
REQ-038 Both requesting continuously, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0... exactly.
REQ-039 Port 1 writes 0xDEADBEEF to address 0x40, then port 0 reads 0x40 -> rsp_we=1 ack, then rsp_rdata=0xDEADBEEF with rsp_port=0.
REQ-040 rst_n pulled low during an OWN1 burst -> gnt and mem_write 0 in the same cycle, rsp_valid=0 after the edge, next grant follows IDLE rule.
REQ-041 DMEM_ARB_STATS_EN defined, 10 cycles of both requesting -> stat_gnt0+stat_gnt1=10, stat_wait=10; undefined -> all counters read 0.
